// File: rtl/fsm_ctrl_pkg.sv
// Shared state encoding and default parameters for the FIFO-supervision controller.
package fsm_ctrl_pkg;

    localparam int N_CH_DEF      = 5;
    localparam int TH_W_DEF      = 5;
    localparam int IDLE_HOLD_DEF = 4;
    localparam int HOLD_W        = 8;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

endpackage

// File: rtl/fsm_ctrl_param_if.sv
// Configuration, channel status and state-indicator bundle of fsm_ctrl_param.
interface fsm_ctrl_param_if
    import fsm_ctrl_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int TH_W = TH_W_DEF
);
    logic                 init;
    logic [N_CH*TH_W-1:0] th_low;
    logic [N_CH*TH_W-1:0] th_high;
    logic [N_CH-1:0]      empties;
    logic [N_CH-1:0]      errors;
    logic                 err_clear;
    logic [N_CH*TH_W-1:0] th_low_q;
    logic [N_CH*TH_W-1:0] th_high_q;
    logic                 idle_out;
    logic                 active_out;
    logic                 error_out;
    logic                 cfg_err;
    logic [N_CH-1:0]      err_src;

    modport master (
        output init, th_low, th_high, empties, errors, err_clear,
        input  th_low_q, th_high_q, idle_out, active_out, error_out, cfg_err, err_src
    );

    modport slave (
        input  init, th_low, th_high, empties, errors, err_clear,
        output th_low_q, th_high_q, idle_out, active_out, error_out, cfg_err, err_src
    );
endinterface

// File: rtl/fsm_ctrl_param_th_check.sv
// Per-channel threshold sanity check: valid when low <= high (unsigned).
module th_check #(
    parameter int TH_W = 5
) (
    input  logic [TH_W-1:0] th_low_i,
    input  logic [TH_W-1:0] th_high_i,
    output logic            ok_o
);
    assign ok_o = (th_low_i <= th_high_i);
endmodule

// File: rtl/fsm_ctrl_param.sv
// Supervisory FSM for N_CH FIFO channels: threshold configuration, idle/active
// tracking with an empty-hold filter, and sticky error capture.
module fsm_ctrl_param
    import fsm_ctrl_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int TH_W      = TH_W_DEF,
    parameter int IDLE_HOLD = IDLE_HOLD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    fsm_ctrl_param_if.slave bus
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IDLE_HOLD - 1);

    state_e               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [N_CH*TH_W-1:0] thl_q, thl_d, thh_q, thh_d;
    logic [N_CH-1:0]      err_src_q, err_src_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [N_CH-1:0]      ch_ok;
    logic                 all_ok;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        th_check #(.TH_W(TH_W)) u_chk (
            .th_low_i  (thl_q[i*TH_W +: TH_W]),
            .th_high_i (thh_q[i*TH_W +: TH_W]),
            .ok_o      (ch_ok[i])
        );
    end
    assign all_ok = &ch_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RESET;
            hold_q    <= '0;
            thl_q     <= '0;
            thh_q     <= '0;
            err_src_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            thl_q     <= thl_d;
            thh_q     <= thh_d;
            err_src_q <= err_src_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        thl_d     = thl_q;
        thh_d     = thh_q;
        err_src_d = err_src_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (bus.init) begin
                    thl_d = bus.th_low;
                    thh_d = bus.th_high;
                end else if (!all_ok) begin
                    state_d   = ST_ERROR;
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (|bus.errors) begin
                    state_d   = ST_ERROR;
                    err_src_d = bus.errors;
                end else if (!(&bus.empties)) begin
                    state_d = ST_ACTIVE;
                    hold_d  = '0;
                end
            end
            ST_ACTIVE: begin
                // Errors override a hold count that completes on the same cycle.
                if (|bus.errors) begin
                    state_d   = ST_ERROR;
                    err_src_d = bus.errors;
                end else if (&bus.empties) begin
                    if (hold_q >= HOLD_LAST) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end else begin
                    hold_d = '0;
                end
            end
            ST_ERROR: begin
                if (bus.err_clear) begin
                    state_d   = ST_INIT;
                    err_src_d = '0;
                    cfg_err_d = 1'b0;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign bus.idle_out   = (state_q == ST_IDLE);
    assign bus.active_out = (state_q == ST_ACTIVE);
    assign bus.error_out  = (state_q == ST_ERROR);
    assign bus.th_low_q   = thl_q;
    assign bus.th_high_q  = thh_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.err_src    = err_src_q;
endmodule
